// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_JFLUSH = 2'd1,
        ST_MWAIT  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX writes.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_targetReg,
    output logic             luse_hit
);

    always_comb begin
        luse_hit = ex_memRead &
                   ((id_use_rs1 & (id_rs1 == ex_targetReg)) |
                    (id_use_rs2 & (id_rs2 == ex_targetReg)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > jump > load-use.
// Optional perf counters when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 15
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_targetReg,
    input  logic             jump_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_clear,
    output logic             idex_clear,
    output logic             exmem_hold,
    output logic             memwb_clear,
    output logic             mem_timeout,
    output logic [1:0]       state_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [15:0]      stall_cnt_o,
    output logic [15:0]      flush_cnt_o
`endif
);

    localparam int unsigned    FCW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FC_LAST   = FCW'(FLUSH_CYCLES - 1);
    localparam logic [3:0]     WAIT_LAST = 4'(MEM_TIMEOUT);

    hz_state_e      state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic           timeout_set;
    logic           luse_hit;
    logic           mem_wait;
    logic           wait_expired;

    load_use_detect u_luse (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_memRead   (ex_memRead),
        .ex_targetReg (ex_targetReg),
        .luse_hit     (luse_hit)
    );

    assign mem_wait     = mem_req & ~mem_ready;
    assign wait_expired = (wcnt_q == WAIT_LAST);
    assign state_o      = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            wcnt_q      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            if (timeout_set)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        wcnt_d      = wcnt_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d = ST_MWAIT;
                    wcnt_d  = 4'd1;
                end else if (jump_taken && (FLUSH_CYCLES > 1)) begin
                    state_d = ST_JFLUSH;
                    fcnt_d  = FCW'(1);
                end
            end
            ST_JFLUSH: begin
                if (mem_wait) begin
                    state_d = ST_MWAIT;
                    wcnt_d  = 4'd1;
                end else if (fcnt_q == FC_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            ST_MWAIT: begin
                if (!mem_wait) begin
                    state_d = ST_RUN;
                end else if (wait_expired) begin
                    state_d     = ST_RUN;
                    timeout_set = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // The release cycle of MWAIT drives nothing; a pending jump is taken up once back in RUN.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_clear  = 1'b0;
        idex_clear  = 1'b0;
        exmem_hold  = 1'b0;
        memwb_clear = 1'b0;
        if (rst) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            memwb_clear = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        exmem_hold  = 1'b1;
                        memwb_clear = 1'b1;
                    end else if (jump_taken) begin
                        ifid_clear = 1'b1;
                        idex_clear = 1'b1;
                    end else if (luse_hit) begin
                        pc_hold    = 1'b1;
                        ifid_hold  = 1'b1;
                        idex_clear = 1'b1;
                    end
                end
                ST_JFLUSH: begin
                    if (mem_wait) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        exmem_hold  = 1'b1;
                        memwb_clear = 1'b1;
                    end else begin
                        ifid_clear = 1'b1;
                        idex_clear = 1'b1;
                    end
                end
                ST_MWAIT: begin
                    if (mem_wait && !wait_expired) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        exmem_hold  = 1'b1;
                        memwb_clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (pc_hold && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 16'd1;
            if (ifid_clear && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=15).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs1, id_rs2, ex_targetReg;
    logic       id_use_rs1, id_use_rs2, ex_memRead;
    logic       jump_taken, mem_req, mem_ready;
    logic       pc_hold, ifid_hold, ifid_clear, idex_clear;
    logic       exmem_hold, memwb_clear, mem_timeout;
    logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt_o, flush_cnt_o;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_memRead   (ex_memRead),
        .ex_targetReg (ex_targetReg),
        .jump_taken   (jump_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .ifid_clear   (ifid_clear),
        .idex_clear   (idex_clear),
        .exmem_hold   (exmem_hold),
        .memwb_clear  (memwb_clear),
        .mem_timeout  (mem_timeout),
        .state_o      (state_o)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
`endif
    );

    // Control bit order: pc_hold, ifid_hold, ifid_clear, idex_clear, exmem_hold, memwb_clear
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_LUSE  = 6'b110100;
    localparam logic [5:0] C_JMP   = 6'b001100;
    localparam logic [5:0] C_STALL = 6'b110011;
    localparam logic [5:0] C_RST   = 6'b001101;

    typedef struct {
        string      tag;
        logic [8:0] vec;
    } sb_t;

    sb_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic idle_inputs();
        id_rs1 = 3'd0; id_rs2 = 3'd0; ex_targetReg = 3'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memRead = 1'b0;
        jump_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic check_head();
        sb_t        e;
        logic [8:0] obs;
        obs = {pc_hold, ifid_hold, ifid_clear, idex_clear, exmem_hold,
               memwb_clear, mem_timeout, state_o};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%b required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                bad++;
                $error("FAIL %s: observed=%b required=%b", e.tag, obs, e.vec);
            end
        end
    endtask

    // Inputs are already applied (posedge+1); expectation queued, checked at the next negedge.
    task automatic step(input string tag, input logic [5:0] ctl,
                        input logic to, input logic [1:0] st);
        sb_t e;
        e.tag = tag;
        e.vec = {ctl, to, st};
        sb.push_back(e);
        @(negedge clk);
        check_head();
`ifdef PIPE_HAZARD_PERF_EN
        if (rst) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (ctl[5]) m_stall++;
            if (ctl[3]) m_flush++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step("reset_outputs", C_RST, 1'b0, 2'd0);
        rst = 1'b0;
        step("idle_run", C_NONE, 1'b0, 2'd0);

        // Load-use detection
        ex_memRead = 1'b1; ex_targetReg = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b1;
        step("luse_rs1", C_LUSE, 1'b0, 2'd0);
        idle_inputs();
        step("luse_after", C_NONE, 1'b0, 2'd0);
        ex_memRead = 1'b1; ex_targetReg = 3'd5; id_rs2 = 3'd5; id_use_rs2 = 1'b1;
        step("luse_rs2", C_LUSE, 1'b0, 2'd0);
        id_use_rs2 = 1'b0;
        step("luse_not_used", C_NONE, 1'b0, 2'd0);
        id_use_rs2 = 1'b1; ex_memRead = 1'b0;
        step("luse_no_load", C_NONE, 1'b0, 2'd0);
        ex_memRead = 1'b1; id_rs2 = 3'd4;
        step("luse_reg_differs", C_NONE, 1'b0, 2'd0);
        idle_inputs();

        // Taken jump, second flush cycle with a load-use hit that must be ignored
        jump_taken = 1'b1;
        step("jump_cycle1", C_JMP, 1'b0, 2'd0);
        jump_taken = 1'b0;
        ex_memRead = 1'b1; ex_targetReg = 3'd2; id_rs1 = 3'd2; id_use_rs1 = 1'b1;
        step("jflush_cycle2", C_JMP, 1'b0, 2'd1);
        idle_inputs();
        step("jump_done", C_NONE, 1'b0, 2'd0);

        // Jump and load-use in the same cycle
        jump_taken = 1'b1;
        ex_memRead = 1'b1; ex_targetReg = 3'd6; id_rs1 = 3'd6; id_use_rs1 = 1'b1;
        step("jump_plus_luse", C_JMP, 1'b0, 2'd0);
        idle_inputs();
        step("jump_plus_luse_fl", C_JMP, 1'b0, 2'd1);
        step("jump_plus_luse_end", C_NONE, 1'b0, 2'd0);

        // Memory wait of 3 cycles
        mem_req = 1'b1; mem_ready = 1'b0;
        step("mwait_enter", C_STALL, 1'b0, 2'd0);
        step("mwait_2", C_STALL, 1'b0, 2'd2);
        step("mwait_3", C_STALL, 1'b0, 2'd2);
        mem_ready = 1'b1;
        step("mwait_ready", C_NONE, 1'b0, 2'd2);
        idle_inputs();
        step("mwait_back_run", C_NONE, 1'b0, 2'd0);

        // Jump arriving while memory waits
        mem_req = 1'b1; jump_taken = 1'b1;
        step("mw_jump_enter", C_STALL, 1'b0, 2'd0);
        step("mw_jump_wait", C_STALL, 1'b0, 2'd2);
        mem_ready = 1'b1;
        step("mw_jump_release", C_NONE, 1'b0, 2'd2);
        mem_req = 1'b0; mem_ready = 1'b0;
        step("mw_jump_flush1", C_JMP, 1'b0, 2'd0);
        jump_taken = 1'b0;
        step("mw_jump_flush2", C_JMP, 1'b0, 2'd1);
        step("mw_jump_done", C_NONE, 1'b0, 2'd0);

        // Timeout: 15 held cycles, forced release on the 16th
        mem_req = 1'b1; mem_ready = 1'b0;
        step("tmo_enter", C_STALL, 1'b0, 2'd0);
        for (int i = 0; i < 14; i++)
            step("tmo_wait", C_STALL, 1'b0, 2'd2);
        step("tmo_release", C_NONE, 1'b0, 2'd2);
        mem_req = 1'b0;
        step("tmo_sticky1", C_NONE, 1'b1, 2'd0);
        step("tmo_sticky2", C_NONE, 1'b1, 2'd0);

        // Async reset between edges while in MWAIT
        mem_req = 1'b1;
        step("rst_pre_enter", C_STALL, 1'b1, 2'd0);
        step("rst_pre_wait", C_STALL, 1'b1, 2'd2);
        rst = 1'b1;
        step("rst_mid_mwait", C_RST, 1'b0, 2'd0);
        rst = 1'b0;
        idle_inputs();
        step("rst_after", C_NONE, 1'b0, 2'd0);

`ifdef PIPE_HAZARD_PERF_EN
        total++;
        assert (stall_cnt_o === 16'(m_stall)) else begin
            bad++;
            $error("FAIL stall_cnt: observed=%0d required=%0d", stall_cnt_o, m_stall);
        end
        total++;
        assert (flush_cnt_o === 16'(m_flush)) else begin
            bad++;
            $error("FAIL flush_cnt: observed=%0d required=%0d", flush_cnt_o, m_flush);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
